// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with RV32I load/store unit for the MEM stage.
// Loads are registered (one-cycle latency); stores commit at the clock edge.
module data_mem_lsu #(
  parameter int MEM_SIZE = 64,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  input  logic [2:0]        funct3,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err
);

  localparam int IDX_W = $clog2(MEM_SIZE);

  logic [7:0] mem [MEM_SIZE];

  logic [2:0]       w_size;
  logic [3:0]       w_be;
  logic             w_aligned;
  logic             w_in_range;
  logic             w_store_f3_ok;
  logic             w_load_f3_ok;
  logic             w_illegal;
  logic             w_st_en;
  logic [ADDR_W:0]  w_end;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_bidx [4];
  logic [7:0]       w_rbyte [4];
  logic [31:0]      w_ldata;

  always_comb begin
    w_size = 3'd0;
    w_be   = 4'b0000;
    case (funct3[1:0])
      2'b00: begin w_size = 3'd1; w_be = 4'b0001; end
      2'b01: begin w_size = 3'd2; w_be = 4'b0011; end
      2'b10: begin w_size = 3'd4; w_be = 4'b1111; end
      default: ;
    endcase
  end

  assign w_store_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
  assign w_load_f3_ok  = w_store_f3_ok || (funct3 == 3'b100) || (funct3 == 3'b101);

  assign w_aligned = (funct3[1:0] == 2'b00)
                  || ((funct3[1:0] == 2'b01) && !addr[0])
                  || ((funct3[1:0] == 2'b10) && (addr[1:0] == 2'b00));

  // One extra bit so an address near the top of the space cannot wrap back into range.
  assign w_end      = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, w_size};
  assign w_in_range = (w_end <= (ADDR_W+1)'(MEM_SIZE));

  assign w_illegal = !w_aligned || !w_in_range
                  || (we && !w_store_f3_ok)
                  || (re && !w_load_f3_ok);
  assign w_st_en   = we && !w_illegal;

  assign w_idx = addr[IDX_W-1:0];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_bidx[k]  = w_idx + IDX_W'(k);
      w_rbyte[k] = mem[w_bidx[k]];
    end
  end

  always_comb begin
    w_ldata = '0;
    case (funct3)
      3'b000: w_ldata = {{24{w_rbyte[0][7]}}, w_rbyte[0]};
      3'b001: w_ldata = {{16{w_rbyte[1][7]}}, w_rbyte[1], w_rbyte[0]};
      3'b010: w_ldata = {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
      3'b100: w_ldata = {24'd0, w_rbyte[0]};
      3'b101: w_ldata = {16'd0, w_rbyte[1], w_rbyte[0]};
      default: ;
    endcase
  end

  // Reads use the pre-edge contents, so a same-cycle load sees the old bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'h00;
    end else begin
      err    <= (we || re) && w_illegal;
      rvalid <= re;
      if (re) rdata <= w_illegal ? 32'd0 : w_ldata;
      if (w_st_en) begin
        for (int k = 0; k < 4; k++) begin
          if (w_be[k]) mem[w_bidx[k]] <= wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: loads, stores, illegal requests,
// read-before-write, back-to-back traffic and reset behaviour.
module tb_data_mem_lsu;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_lsu #(.MEM_SIZE(64), .ADDR_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .re     (re),
    .funct3 (funct3),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one request, clock it, and return 1 time unit after the edge.
  task automatic drive(input logic w, input logic r, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; funct3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memw(input int a);
    return {dut.mem[a+3], dut.mem[a+2], dut.mem[a+1], dut.mem[a]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nz;
    rst = 1'b1; we = 1'b0; re = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    @(posedge clk); #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // 1: basic word store
    drive(1, 0, F_W, 28, 32'h0000_0003);
    check("sw28_mem", memw(28), 32'h0000_0003);
    check("sw28_err", {31'd0, err}, 32'd0);
    check("sw28_rvalid", {31'd0, rvalid}, 32'd0);

    // 2: sign/zero extension
    drive(1, 0, F_W, 12, 32'h80FF_7F01);
    drive(0, 1, F_B, 14, 0);
    check("lb14", rdata, 32'hFFFF_FFFF);
    check("lb14_rvalid", {31'd0, rvalid}, 32'd1);
    drive(0, 1, F_BU, 14, 0);
    check("lbu14", rdata, 32'h0000_00FF);
    drive(0, 1, F_H, 14, 0);
    check("lh14", rdata, 32'hFFFF_80FF);
    drive(0, 1, F_HU, 14, 0);
    check("lhu14", rdata, 32'h0000_80FF);
    drive(0, 1, F_B, 13, 0);
    check("lb13_pos", rdata, 32'h0000_007F);
    drive(0, 1, F_W, 12, 0);
    check("lw12", rdata, 32'h80FF_7F01);
    drive(0, 0, F_W, 0, 0);
    check("idle_rvalid", {31'd0, rvalid}, 32'd0);
    check("idle_rdata_hold", rdata, 32'h80FF_7F01);

    // 3: illegal requests
    drive(1, 0, F_H, 13, 32'h0000_AAAA);
    check("sh13_err", {31'd0, err}, 32'd1);
    check("sh13_mem", memw(12), 32'h80FF_7F01);
    drive(0, 0, F_W, 0, 0);
    check("err_one_cycle", {31'd0, err}, 32'd0);
    drive(1, 0, F_W, 62, 32'h1234_5678);
    check("sw62_err", {31'd0, err}, 32'd1);
    check("sw62_mem", memw(60), 32'h0);
    drive(0, 1, F_W, 62, 0);
    check("lw62_rdata", rdata, 32'h0);
    check("lw62_rvalid", {31'd0, rvalid}, 32'd1);
    check("lw62_err", {31'd0, err}, 32'd1);
    drive(1, 0, F_BU, 28, 32'hFFFF_FFFF);
    check("sbu_err", {31'd0, err}, 32'd1);
    check("sbu_mem", memw(28), 32'h0000_0003);
    drive(0, 1, 3'b011, 0, 0);
    check("ld011_err", {31'd0, err}, 32'd1);
    check("ld011_rdata", rdata, 32'h0);

    // top-of-memory boundary is legal
    drive(1, 0, F_W, 60, 32'h1122_3344);
    check("sw60_err", {31'd0, err}, 32'd0);
    drive(0, 1, F_W, 60, 0);
    check("lw60", rdata, 32'h1122_3344);
    drive(0, 1, F_BU, 63, 0);
    check("lbu63", rdata, 32'h0000_0011);

    // 4: read-before-write
    drive(1, 0, F_W, 20, 32'h0000_0005);
    drive(1, 1, F_W, 20, 32'hAABB_CCDD);
    check("rbw_old", rdata, 32'h0000_0005);
    drive(0, 1, F_W, 20, 0);
    check("rbw_new", rdata, 32'hAABB_CCDD);

    // 5: back-to-back
    drive(1, 0, F_W, 24, 32'h0000_0002);
    drive(0, 1, F_W, 24, 0);
    check("b2b_lw1", rdata, 32'h0000_0002);
    drive(1, 0, F_B, 24, 32'hFFFF_FF7F);
    drive(0, 1, F_W, 24, 0);
    check("b2b_lw2", rdata, 32'h0000_007F);
    check("b2b_rvalid", {31'd0, rvalid}, 32'd1);

    // 6: load then reset, with a request held during the reset cycle
    drive(0, 1, F_W, 20, 0);
    check("pre_rst_lw", rdata, 32'hAABB_CCDD);
    rst = 1'b1;
    drive(1, 1, F_W, 0, 32'hFFFF_FFFF);
    check("rst2_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst2_rdata", rdata, 32'h0);
    check("rst2_err", {31'd0, err}, 32'd0);
    nz = 0;
    for (int i = 0; i < 64; i++) if (dut.mem[i] != 8'h00) nz++;
    check("rst2_mem_zero", nz, 0);
    rst = 1'b0;
    drive(0, 0, F_W, 0, 0);
    check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
